// File: rtl/semaphore_lamp_driver.sv
// Registered lamp driver behind semaphore_fsm: follows lamp requests, blinks yellow in OFF and latches
// faults into a flashing-yellow safe mode. Optional stuck-state watchdog: SEMAPHORE_LAMP_WDOG_EN.
//   state    | meaning
//   ST_RUN   | lamps follow red/yellow/green requests
//   ST_BLINK | FSM reports OFF, yellow lamp blinks
//   ST_SAFE  | fault latched, yellow blinks until fault_clr with no condition present
module semaphore_lamp_driver #(
    parameter int BLINK_HALF  = 4,
    parameter int WDOG_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       red,
    input  logic       yellow,
    input  logic       green,
    input  logic [3:0] state_out,
    input  logic       fault_clr,
    output logic       lamp_red,
    output logic       lamp_yellow,
    output logic       lamp_green,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam logic [3:0] CODE_OFF        = 4'b0001;
    localparam logic [3:0] CODE_RED        = 4'b0010;
    localparam logic [3:0] CODE_YELLOW     = 4'b0101;
    localparam logic [3:0] CODE_YELLOW_RED = 4'b0011;
    localparam logic [3:0] CODE_GREEN      = 4'b0100;

    localparam int               CNT_W  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(BLINK_HALF - 1);

    if (BLINK_HALF < 1 || WDOG_CYCLES < 1 || WDOG_CYCLES > 65535) begin : g_bad_param
        $error("semaphore_lamp_driver: BLINK_HALF or WDOG_CYCLES out of range");
    end

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_BLINK = 2'd1,
        ST_SAFE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    logic [2:0]       lamps_d;
    logic             fault_d;
    logic [1:0]       code_d;

    logic [2:0]       exp_lamps;
    logic             code_legal;
    logic             cond_illegal;
    logic             cond_mismatch;
    logic             cond_wdog;
    logic             any_cond;
    logic [1:0]       cond_code;

    always_comb begin
        exp_lamps  = 3'b000;
        code_legal = 1'b1;
        case (state_out)
            CODE_OFF:        exp_lamps = 3'b000;
            CODE_RED:        exp_lamps = 3'b100;
            CODE_YELLOW_RED: exp_lamps = 3'b110;
            CODE_GREEN:      exp_lamps = 3'b001;
            CODE_YELLOW:     exp_lamps = 3'b010;
            default:         code_legal = 1'b0;
        endcase
    end

    always_comb begin
        cond_illegal  = !code_legal;
        cond_mismatch = code_legal && ({red, yellow, green} != exp_lamps);
        any_cond      = cond_illegal || cond_mismatch || cond_wdog;
        if (cond_illegal)       cond_code = 2'd1;
        else if (cond_mismatch) cond_code = 2'd2;
        else if (cond_wdog)     cond_code = 2'd3;
        else                    cond_code = 2'd0;
    end

`ifdef SEMAPHORE_LAMP_WDOG_EN
    localparam logic [15:0] WDOG_LIMIT = 16'(WDOG_CYCLES);

    logic [15:0] wdog_q, wdog_d;
    logic [3:0]  prev_code_q;

    // The count only advances while a non-OFF code is held, so it is effectively a RUN/SAFE
    // timer; keeping it state-independent also blocks fault_clr while the stall persists.
    always_comb begin
        wdog_d = wdog_q;
        if (state_out == CODE_OFF || state_out != prev_code_q)
            wdog_d = '0;
        else if (wdog_q != 16'hFFFF)
            wdog_d = wdog_q + 16'd1;
        cond_wdog = (wdog_d >= WDOG_LIMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q      <= '0;
            prev_code_q <= '0;
        end else begin
            wdog_q      <= wdog_d;
            prev_code_q <= state_out;
        end
    end
`else
    always_comb cond_wdog = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        fault_d = fault;
        code_d  = fault_code;

        case (state_q)
            ST_RUN: begin
                if (any_cond) begin
                    state_d = ST_SAFE;
                    fault_d = 1'b1;
                    code_d  = cond_code;
                end else if (state_out == CODE_OFF) begin
                    state_d = ST_BLINK;
                end
            end
            ST_BLINK: begin
                if (any_cond) begin
                    state_d = ST_SAFE;
                    fault_d = 1'b1;
                    code_d  = cond_code;
                end else if (state_out != CODE_OFF) begin
                    state_d = ST_RUN;
                end
            end
            ST_SAFE: begin
                if (fault_clr && !any_cond) begin
                    state_d = (state_out == CODE_OFF) ? ST_BLINK : ST_RUN;
                    fault_d = 1'b0;
                    code_d  = 2'd0;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Any entry into a blinking state restarts with yellow ON for a full half-period.
    always_comb begin
        blink_cnt_d   = '0;
        blink_phase_d = 1'b0;
        lamps_d       = {red, yellow, green};
        if (state_d != ST_RUN) begin
            if (state_d != state_q) begin
                blink_cnt_d   = '0;
                blink_phase_d = 1'b1;
            end else if (blink_cnt_q == CNT_TC) begin
                blink_cnt_d   = '0;
                blink_phase_d = !blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + 1'b1;
                blink_phase_d = blink_phase_q;
            end
            lamps_d = {1'b0, blink_phase_d, 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            lamp_red      <= 1'b0;
            lamp_yellow   <= 1'b0;
            lamp_green    <= 1'b0;
            fault         <= 1'b0;
            fault_code    <= 2'd0;
        end else begin
            state_q       <= state_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            lamp_red      <= lamps_d[2];
            lamp_yellow   <= lamps_d[1];
            lamp_green    <= lamps_d[0];
            fault         <= fault_d;
            fault_code    <= code_d;
        end
    end

endmodule

// File: tb/tb_semaphore_lamp_driver.sv
// Scoreboard bench for semaphore_lamp_driver: each stimulus cycle queues the expected
// {lamp_red, lamp_yellow, lamp_green, fault, fault_code} and a monitor checks it after the edge.
module tb_semaphore_lamp_driver;

    localparam logic [3:0] OFF = 4'b0001;
    localparam logic [3:0] RD  = 4'b0010;
    localparam logic [3:0] YL  = 4'b0101;
    localparam logic [3:0] YR  = 4'b0011;
    localparam logic [3:0] GR  = 4'b0100;
    localparam logic [3:0] BAD = 4'b1111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       red = 1'b0, yellow = 1'b0, green = 1'b0;
    logic [3:0] state_out = OFF;
    logic       fault_clr = 1'b0;
    logic       lamp_red, lamp_yellow, lamp_green, fault;
    logic [1:0] fault_code;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [5:0] exp;
    } exp_t;

    exp_t sb[$];

    semaphore_lamp_driver #(.BLINK_HALF(4), .WDOG_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .red(red), .yellow(yellow), .green(green),
        .state_out(state_out), .fault_clr(fault_clr),
        .lamp_red(lamp_red), .lamp_yellow(lamp_yellow), .lamp_green(lamp_green),
        .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {lamp_red, lamp_yellow, lamp_green, fault, fault_code};
    endfunction

    task automatic check_now(input string nm, input logic [5:0] exp);
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b", nm, outs(), exp);
        end
    endtask

    // One cycle of stimulus; exp is the output word expected after the following rising edge.
    task automatic step(input logic [3:0] so, input logic [2:0] rgb, input logic clr,
                        input logic [5:0] exp, input string nm);
        exp_t e;
        @(negedge clk);
        state_out = so;
        {red, yellow, green} = rgb;
        fault_clr = clr;
        e.name = nm;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_now(e.name, e.exp);
            end
        end
    end

    initial begin : stimulus
        repeat (2) @(posedge clk);
        #1;
        check_now("reset_outputs", 6'b000_0_00);
        rst = 1'b0;

        // OFF blink after reset: yellow ON 4 cycles, OFF 4 cycles
        for (int i = 0; i < 10; i++)
            step(OFF, 3'b000, 1'b0, ((i % 8) < 4) ? 6'b010_0_00 : 6'b000_0_00, "off_blink");

        // Normal cycle
        step(RD, 3'b100, 1'b0, 6'b100_0_00, "run_red");
        step(RD, 3'b100, 1'b0, 6'b100_0_00, "run_red");
        step(YR, 3'b110, 1'b0, 6'b110_0_00, "run_yellow_red");
        step(YR, 3'b110, 1'b0, 6'b110_0_00, "run_yellow_red");
        step(GR, 3'b001, 1'b0, 6'b001_0_00, "run_green");
        step(GR, 3'b001, 1'b0, 6'b001_0_00, "run_green");
        step(YL, 3'b010, 1'b0, 6'b010_0_00, "run_yellow");
        step(RD, 3'b100, 1'b0, 6'b100_0_00, "run_red2");

        // Lamp mismatch, then clear attempts
        step(GR, 3'b101, 1'b0, 6'b010_1_10, "mismatch_enter");
        for (int i = 0; i < 3; i++)
            step(GR, 3'b101, 1'b0, 6'b010_1_10, "mismatch_hold");
        step(GR, 3'b101, 1'b1, 6'b000_1_10, "clr_while_faulty");
        step(GR, 3'b001, 1'b0, 6'b000_1_10, "safe_legal_no_clr");
        step(GR, 3'b001, 1'b1, 6'b001_0_00, "clr_to_run");
        step(GR, 3'b001, 1'b0, 6'b001_0_00, "run_after_clr");
        step(RD, 3'b100, 1'b1, 6'b100_0_00, "clr_ignored_run");

        // Illegal code with simultaneous lamp disagreement
        step(BAD, 3'b001, 1'b0, 6'b010_1_01, "illegal_enter");
        step(BAD, 3'b001, 1'b0, 6'b010_1_01, "illegal_hold");
        step(OFF, 3'b000, 1'b1, 6'b010_0_00, "clr_to_blink");
        step(OFF, 3'b000, 1'b0, 6'b010_0_00, "blink_after_clr");

        // Fault from BLINK; a later fault must not overwrite the first code
        step(RD, 3'b000, 1'b0, 6'b010_1_10, "blink_mismatch");
        step(BAD, 3'b000, 1'b0, 6'b010_1_10, "first_code_kept");
        step(BAD, 3'b000, 1'b1, 6'b010_1_10, "clr_illegal_ignored");
        step(RD, 3'b100, 1'b1, 6'b100_0_00, "clr_to_run2");
        step(OFF, 3'b000, 1'b0, 6'b010_0_00, "enter_blink");
        step(GR, 3'b001, 1'b0, 6'b001_0_00, "blink_exit_green");
        step(GR, 3'b001, 1'b0, 6'b001_0_00, "run_green2");

        // Asynchronous reset mid-operation
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_now("async_reset", 6'b000_0_00);
        @(posedge clk);
        #1 rst = 1'b0;
        step(OFF, 3'b000, 1'b0, 6'b010_0_00, "blink_after_reset");
        step(OFF, 3'b000, 1'b0, 6'b010_0_00, "blink_after_reset");

        // Stuck RED
`ifdef SEMAPHORE_LAMP_WDOG_EN
        for (int i = 0; i < 64; i++)
            step(RD, 3'b100, 1'b0, 6'b100_0_00, "wdog_pre");
        step(RD, 3'b100, 1'b0, 6'b010_1_11, "wdog_fire");
        step(RD, 3'b100, 1'b1, 6'b010_1_11, "wdog_clr_blocked");
`else
        for (int i = 0; i < 200; i++)
            step(RD, 3'b100, 1'b0, 6'b100_0_00, "no_wdog_red_hold");
`endif

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
